// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the data memory responder.
// Holds the access-size code, the responder state encoding and small
// decode helpers used by the top level.
package mem_pkg;

   // Access size as carried on req_size.
   typedef enum logic [1:0] {
      SZ_NONE = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_WORD = 2'b11
   } sz_e;

   // Responder states; ACC2 is only used by accesses split across two words.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC1 = 2'b01,
      ACC2 = 2'b10,
      RESP = 2'b11
   } state_e;

   // Number of bytes moved by an access of the given size.
   function automatic logic [2:0] size_bytes(input sz_e sz);
      case (sz)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         SZ_WORD: size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

   // Byte-lane mask of an access of the given size before lane alignment.
   function automatic logic [3:0] size_mask(input sz_e sz);
      case (sz)
         SZ_BYTE: size_mask = 4'b0001;
         SZ_HALF: size_mask = 4'b0011;
         SZ_WORD: size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: word-wide data array with four byte-lane write enables
// and a one-cycle synchronous read (read-before-write on the same word).
module byte_lane_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Array write per enabled lane, and registered read of the addressed word.
   // NOTE: the array has no reset on purpose; clearing it would turn a RAM
   // macro into a flop array, and software must not rely on initial contents.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (we[lane]) begin
               // NOTE: clocked state uses non-blocking assignments so every
               // flop samples pre-edge values regardless of statement order.
               mem_q[addr][8*lane +: 8] <= wdata[8*lane +: 8];
            end
         end
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder for the memory stage.
// Registers one request, accesses the byte-lane array in ACC1 (and ACC2 for
// an access that straddles two words) and returns a one-cycle response.
// Build option: MISALIGN_SPLIT_EN -- when defined, misaligned half/word
// accesses are completed (split across words if needed); otherwise they
// respond with an access fault.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_e      state_q, state_d;
   sz_e         size_q, size_d;
   logic        write_q, write_d;
   logic        unsigned_q, unsigned_d;
   logic        none_done_q, none_done_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] lo_q, lo_d;

   logic [1:0]  off;
   logic [2:0]  nbytes;
   logic [30:0] w_lo, w_hi;
   logic        crosses, range_err, acc_err, need_split;
   logic [7:0]  be_wide;
   logic [63:0] wdata_wide;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic [31:0] lo_word, hi_word, load_raw, load_ext;
   logic        in_resp;

   // Decode of the registered request; word indices carry an extra bit so
   // W+1 never wraps.
   assign off       = addr_q[1:0];
   assign nbytes    = size_bytes(size_q);
   assign w_lo      = {1'b0, addr_q[31:2]};
   assign w_hi      = w_lo + 31'd1;
   assign crosses   = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
   assign range_err = (w_lo >= 31'(DEPTH_WORDS)) || (crosses && (w_hi >= 31'(DEPTH_WORDS)));

`ifdef MISALIGN_SPLIT_EN
   assign acc_err    = range_err;
   assign need_split = crosses;
`else
   logic misaligned;
   assign misaligned = ((size_q == SZ_HALF) && off[0]) ||
                       ((size_q == SZ_WORD) && (off != 2'b00));
   assign acc_err    = range_err || misaligned;
   assign need_split = 1'b0;
`endif

   // Lane-aligned enables and data over a two-word window: low half goes
   // to word W, high half to word W+1.
   assign be_wide    = {4'b0000, size_mask(size_q)} << off;
   assign wdata_wide = {32'h0, wdata_q} << {off, 3'b000};

   // Array port control: accesses happen only in ACC1/ACC2 and never on a
   // reset edge, so a reset during ACC2 suppresses the second write.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first;
      // a path that leaves one unassigned would infer a latch.
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_addr  = '0;
      ram_wdata = 32'h0;
      if (!rst) begin
         case (state_q)
            ACC1: begin
               if (!acc_err) begin
                  ram_en    = 1'b1;
                  ram_addr  = w_lo[AW-1:0];
                  ram_we    = write_q ? be_wide[3:0] : 4'b0000;
                  ram_wdata = wdata_wide[31:0];
               end
            end
            ACC2: begin
               ram_en    = 1'b1;
               ram_addr  = w_hi[AW-1:0];
               ram_we    = write_q ? be_wide[7:4] : 4'b0000;
               ram_wdata = wdata_wide[63:32];
            end
            default: ;
         endcase
      end
   end

   byte_lane_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Load data: realign the one or two words read, then size-extend.
   assign lo_word  = need_split ? lo_q : ram_rdata;
   assign hi_word  = need_split ? ram_rdata : 32'h0;
   assign load_raw = 32'({hi_word, lo_word} >> {off, 3'b000});

   // Sign or zero extension by access size; word loads pass through.
   always_comb begin
      load_ext = 32'h0;
      case (size_q)
         SZ_BYTE: load_ext = {{24{~unsigned_q & load_raw[7]}}, load_raw[7:0]};
         SZ_HALF: load_ext = {{16{~unsigned_q & load_raw[15]}}, load_raw[15:0]};
         SZ_WORD: load_ext = load_raw;
         default: load_ext = 32'h0;
      endcase
   end

   // A size-00 request skips the array and answers from IDLE one cycle after
   // RESP, so it keeps the same two-cycle latency as an unsplit access.
   assign in_resp   = (state_q == RESP) && (size_q != SZ_NONE);
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = in_resp || none_done_q;
   assign rsp_err   = in_resp && acc_err;
   assign rsp_rdata = (in_resp && !acc_err && !write_q) ? load_ext : 32'h0;

   // Next-state and request capture.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      write_d     = write_q;
      unsigned_d  = unsigned_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lo_d        = lo_q;
      none_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               size_d     = sz_e'(req_size);
               write_d    = req_write;
               unsigned_d = req_unsigned;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               state_d    = (sz_e'(req_size) == SZ_NONE) ? RESP : ACC1;
            end
         end
         ACC1: state_d = (!acc_err && need_split) ? ACC2 : RESP;
         ACC2: begin
            lo_d    = ram_rdata;
            state_d = RESP;
         end
         RESP: begin
            none_done_d = (size_q == SZ_NONE);
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         size_q      <= SZ_NONE;
         write_q     <= 1'b0;
         unsigned_q  <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         lo_q        <= 32'h0;
         none_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         write_q     <= write_d;
         unsigned_q  <= unsigned_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lo_q        <= lo_d;
         none_done_q <= none_done_d;
      end
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal data array.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port req_valid, input, 1: memory-stage request present.
REQ-005 Port req_ready, output, 1: block can accept a request.
REQ-006 Port req_write, input, 1: 1 = store, 0 = load.
REQ-007 Port req_size, input, 2: access size; 00 none, 01 byte, 10 half-word, 11 word.
REQ-008 Port req_unsigned, input, 1: 1 = zero-extend load data (fn3[2]); ignored for stores.
REQ-009 Port req_addr, input, 32: byte address.
REQ-010 Port req_wdata, input, 32: store data; low size-bytes used.
REQ-011 Port rsp_valid, output, 1: one-cycle response pulse.
REQ-012 Port rsp_rdata, output, 32: extended load data; 0 for stores, size 00 and errors.
REQ-013 Port rsp_err, output, 1: access fault, qualified by rsp_valid.

Function
REQ-014 The block SHALL accept a request only when req_valid and req_ready are both 1; req_ready SHALL be 1 only in state IDLE.
REQ-015 States: IDLE, ACC1, ACC2, RESP. Transitions: IDLE->ACC1 on accept; ACC1->ACC2 if split needed, else ACC1->RESP; ACC2->RESP; RESP->IDLE.
REQ-016 Size 00 SHALL go IDLE->RESP with no array access, rsp_err 0 and rsp_rdata 0.
REQ-017 Latency from accept cycle N: rsp_valid at N+2 for an unsplit access and at N+3 for a split access.
REQ-018 Out-of-range access, where any touched word index >= DEPTH_WORDS, SHALL respond with rsp_err=1, perform no write, and take unsplit latency.
REQ-019 Stores SHALL write only the addressed byte lanes with req_wdata[8*size-1:0], starting at the lane given by addr[1:0].
REQ-020 Loads SHALL sign-extend from bit 7 or 15, or zero-extend when req_unsigned=1; word loads SHALL be returned unmodified.
REQ-021 Crossing: byte offset plus size in bytes > 4; a split access SHALL touch word W in ACC1 and word W+1 in ACC2, and no array access SHALL occur outside ACC1/ACC2.
REQ-022 Request fields SHALL be registered at accept; input changes after acceptance SHALL have no effect.
REQ-023 Word address wrap beyond 32 bits SHALL NOT occur; W+1 is out-of-range if W = DEPTH_WORDS-1.

Reset
REQ-024 On rst: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, all request registers 0.
REQ-025 Reset mid-operation SHALL abort the access with no response; an ACC1 write already committed SHALL remain, and the pending ACC2 write SHALL NOT occur.
REQ-026 Array contents SHALL NOT be reset.

Configuration
REQ-027 Macro MISALIGN_SPLIT_EN: when defined, misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) SHALL complete per REQ-019 to REQ-021.
REQ-028 When MISALIGN_SPLIT_EN is undefined, every misaligned access SHALL respond with rsp_err=1 and no write, and ACC2 SHALL be unreachable.

Structure
REQ-029 Package mem_pkg SHALL hold the size-code enum (SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-030 Sub-module byte_lane_ram SHALL implement the word-wide array with 4 byte enables and 1-cycle synchronous read.

Verification
REQ-031 Store word 0xDEADBEEF at 0x10, then load byte signed at 0x13 -> rsp_rdata 0xFFFFFFDE, err 0, latency 2.
REQ-032 Load half unsigned at 0x12 after REQ-031 -> rsp_rdata 0x0000DEAD.
REQ-033 With MISALIGN_SPLIT_EN, store word 0x11223344 at 0x0E, then load word at 0x0E -> rsp_rdata 0x11223344, latency 3, and words 0x0C and 0x10 hold 0x3344xxxx and xxxx1122 respectively; without the macro -> err 1, memory unchanged.
REQ-034 Load word at byte address 4*DEPTH_WORDS -> rsp_err 1, rsp_rdata 0.
REQ-035 Assert rst during ACC2 of a split store -> no rsp_valid, second word unchanged, req_ready 1 on the next cycle.
REQ-036 req_size 00 with req_valid -> rsp_valid at N+2, err 0, rdata 0, array unchanged.
